// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM encodings and port indices for the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // The pointer port wins when it asks; otherwise the other port takes the slot.
  always_comb begin
    grant = 2'b00;
    if (valid[pointer])
      grant[pointer] = 1'b1;
    else if (valid[~pointer])
      grant[~pointer] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin front end for a single-port word memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t        state, next;
  logic          pointer;
  logic          port_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    count;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [1:0]    grant;
  logic          cap_en;
  logic [DW-1:0] cap_data;

  rr_arb2 u_pick (
    .valid   ({req1_valid, req0_valid}),
    .pointer (pointer),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = !rst && grant[0];
        req1_ready = !rst && grant[1];
        if (grant != 2'b00) next = ACCESS;
      end
      ACCESS: begin
        mem_wr_en = we_q;
        if (we_q || RD_LAT == 0) next = RESP;
        else                     next = WAIT;
      end
      WAIT: begin
        if (count == 2'd1) next = RESP;
      end
      RESP: begin
        rsp0_valid = (port_q == PORT0);
        rsp1_valid = (port_q == PORT1);
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Writes report zero data; reads capture on the edge where mem_data_out is valid.
  assign cap_en   = (state == ACCESS && (we_q || RD_LAT == 0)) || (state == WAIT && count == 2'd1);
  assign cap_data = we_q ? '0 : mem_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer  <= PORT0;
      port_q   <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      count    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state == IDLE && grant != 2'b00) begin
        port_q  <= grant[1];
        we_q    <= grant[1] ? req1_we    : req0_we;
        addr_q  <= grant[1] ? req1_addr  : req0_addr;
        wdata_q <= grant[1] ? req1_wdata : req0_wdata;
      end
      if (state == ACCESS && !we_q) count <= LAT;
      else if (state == WAIT)       count <= count - 2'd1;
      if (cap_en) begin
        if (port_q == PORT1) rdata1_q <= cap_data;
        else                 rdata0_q <= cap_data;
      end
      if (state == RESP) pointer <= ~port_q;
    end
  end

  assign mem_addr    = addr_q & ~AW'(3);
  assign mem_data_in = wdata_q;
  assign rsp0_rdata  = rdata0_q;
  assign rsp1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a behavioural word memory
module tb_mem_arbiter;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_wr_en;
  logic [31:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_data_in, mem_data_out;

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Word memory with one cycle of read latency.
  logic [31:0] mem_arr [0:255];
  logic [31:0] rd_q = 32'h0;
  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_addr[9:2]] <= mem_data_in;
    rd_q <= mem_arr[mem_addr[9:2]];
  end
  assign mem_data_out = rd_q;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: grant order, responses, one transaction in flight.
  int          grant_q[$];
  int          rsp_port_q[$];
  logic [31:0] rsp_data_q[$];
  bit          inflight = 0;
  logic        prev_v0 = 0, prev_r0 = 0, prev_v1 = 0, prev_r1 = 0;

  always @(posedge rst) inflight = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready && req1_ready) begin
        tests++; fails++; $display("FAIL both_ready: got 1 required 0");
      end
      if ((req0_ready || req1_ready) && inflight) begin
        tests++; fails++; $display("FAIL ready_outside_idle: got 1 required 0");
      end
      if ((prev_v0 && !prev_r0 && !req0_valid) || (prev_v1 && !prev_r1 && !req1_valid)) begin
        tests++; fails++; $display("FAIL valid_dropped_before_ready: got 0 required 1");
      end
      if (req0_ready || req1_ready) begin
        grant_q.push_back(req1_ready ? 1 : 0);
        inflight = 1;
      end
      if (rsp0_valid || rsp1_valid) begin
        if (!inflight) begin
          tests++; fails++; $display("FAIL spurious_rsp: got 1 required 0");
        end
        rsp_port_q.push_back(rsp1_valid ? 1 : 0);
        rsp_data_q.push_back(rsp1_valid ? rsp1_rdata : rsp0_rdata);
        inflight = 0;
      end
    end
    prev_v0 = req0_valid; prev_r0 = req0_ready;
    prev_v1 = req1_valid; prev_r1 = req1_ready;
  end

  task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    if (p == 0) begin req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  // Single request; reports read data, negedges from accept to response, ACCESS address, writes seen.
  task automatic do_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output logic [31:0] maddr,
                        output int wr_cnt);
    bit got = 0;
    rd = 32'hx; lat = -1; maddr = 32'hx; wr_cnt = 0;
    @(posedge clk); #3;
    set_req(p, 1'b1, we, a, d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy(p)) begin got = 1; break; end
    end
    @(posedge clk); #3;
    set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!got) return;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) maddr = mem_addr;
      if (mem_wr_en) wr_cnt++;
      if ((p == 0 && rsp0_valid) || (p == 1 && rsp1_valid)) begin
        lat = n;
        rd  = (p == 0) ? rsp0_rdata : rsp1_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;
  op_t ops [2][8];

  // Issues n queued ops on one port back to back, valid held continuously.
  task automatic drive_port(input int p, input int n);
    bit got;
    @(posedge clk); #3;
    for (int k = 0; k < n; k++) begin
      set_req(p, 1'b1, ops[p][k].we, ops[p][k].addr, ops[p][k].wdata);
      got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rdy(p)) begin got = 1; break; end
      end
      if (!got) begin
        tests++; fails++;
        $display("FAIL accept_timeout_port%0d: got 0 required 1", p);
      end
      @(posedge clk); #3;
    end
    set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_rsps(input int n);
    for (int i = 0; i < 200; i++) begin
      if (rsp_port_q.size() >= n) break;
      @(negedge clk);
    end
    check("rsp_count", rsp_port_q.size(), n);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] exp4 [4];
  logic [31:0] rd, maddr;
  int          lat, wr_cnt, idx0, idx1;
  bit          got, saw;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA000_0000 + i;

    vecs[0] = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0,        32'h04, 2};
    vecs[1] = '{0, 1'b0, 32'h04, 32'h0,        32'hDEADBEEF, 32'h04, 2 + RD_LAT};
    vecs[2] = '{1, 1'b0, 32'h10, 32'h0,        32'hA0000004, 32'h10, 2 + RD_LAT};
    vecs[3] = '{1, 1'b1, 32'h10, 32'h12345678, 32'h0,        32'h10, 2};
    vecs[4] = '{1, 1'b0, 32'h10, 32'h0,        32'h12345678, 32'h10, 2 + RD_LAT};
    vecs[5] = '{0, 1'b0, 32'h07, 32'h0,        32'hDEADBEEF, 32'h04, 2 + RD_LAT};
    vecs[6] = '{1, 1'b0, 32'h03, 32'h0,        32'hA0000000, 32'h00, 2 + RD_LAT};
    vecs[7] = '{0, 1'b1, 32'hFC, 32'hFFFFFFFF, 32'h0,        32'hFC, 2};
    vecs[8] = '{1, 1'b0, 32'hFC, 32'h0,        32'hFFFFFFFF, 32'hFC, 2 + RD_LAT};

    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("reset_ctrl_outputs", {27'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_wr_en}, 32'h0);
    check("reset_rsp0_rdata", rsp0_rdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #3 rst = 1'b0;

    foreach (vecs[v]) begin
      do_req(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, lat, maddr, wr_cnt);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_mem_addr", v), maddr, vecs[v].exp_maddr);
      check($sformatf("vec%0d_wr_cycles", v), wr_cnt, vecs[v].we ? 1 : 0);
    end

    // Port 0 read leaves the pointer at port 1, then reset hits a port 1 read during WAIT.
    do_req(0, 1'b0, 32'h0, 32'h0, rd, lat, maddr, wr_cnt);
    check("pre_reset_read", rd, 32'hA0000000);
    @(posedge clk); #3;
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h55AA55AA);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_ready) begin got = 1; break; end
    end
    check("rst_seq_accept", {31'h0, got}, 32'h1);
    @(posedge clk); #3;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ctrl_outputs", {27'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_wr_en}, 32'h0);
    check("midrst_rsp0_rdata", rsp0_rdata, 32'h0);
    check("midrst_rsp1_rdata", rsp1_rdata, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_mem_data_in", mem_data_in, 32'h0);
    @(posedge clk); #3 rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp1_valid) saw = 1;
    end
    check("midrst_no_rsp1", {31'h0, saw}, 32'h0);

    // Simultaneous requests after reset: port 0 write first, port 1 reads the new value.
    grant_q.delete(); rsp_port_q.delete(); rsp_data_q.delete();
    ops[0][0] = '{1'b1, 32'h08, 32'h11111111};
    ops[1][0] = '{1'b0, 32'h08, 32'h0};
    fork
      drive_port(0, 1);
      drive_port(1, 1);
    join
    wait_rsps(2);
    if (grant_q.size() == 2) begin
      check("both_grant_first", grant_q[0], 0);
      check("both_grant_second", grant_q[1], 1);
    end else check("both_grant_count", grant_q.size(), 2);
    if (rsp_port_q.size() == 2) begin
      check("both_rsp_port_order", {rsp_port_q[0][15:0], rsp_port_q[1][15:0]}, 32'h0000_0001);
      check("both_port1_rdata", rsp_data_q[1], 32'h11111111);
    end

    // Continuous load: 8 reads per port over 0x0..0xC.
    exp4[0] = 32'hA0000000; exp4[1] = 32'hDEADBEEF;
    exp4[2] = 32'h11111111; exp4[3] = 32'hA0000003;
    grant_q.delete(); rsp_port_q.delete(); rsp_data_q.delete();
    for (int k = 0; k < 8; k++) begin
      ops[0][k] = '{1'b0, 32'(k % 4) * 4, 32'h0};
      ops[1][k] = '{1'b0, 32'(k % 4) * 4, 32'h0};
    end
    fork
      drive_port(0, 8);
      drive_port(1, 8);
    join
    wait_rsps(16);
    check("load_grant_count", grant_q.size(), 16);
    saw = 0;
    foreach (grant_q[i]) if (grant_q[i] != i % 2) saw = 1;
    check("load_grant_alternation", {31'h0, saw}, 32'h0);
    idx0 = 0; idx1 = 0;
    foreach (rsp_port_q[i]) begin
      if (rsp_port_q[i] == 0) begin
        check($sformatf("load_p0_rd%0d", idx0), rsp_data_q[i], exp4[idx0 % 4]);
        idx0++;
      end else begin
        check($sformatf("load_p1_rd%0d", idx1), rsp_data_q[i], exp4[idx1 % 4]);
        idx1++;
      end
    end
    check("load_p0_rsps", idx0, 8);
    check("load_p1_rsps", idx1, 8);
    repeat (3) @(negedge clk);
    check("rsp0_rdata_holds", rsp0_rdata, exp4[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
